// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the in-order writeback stage
//   and a long-latency unit (divider / uncached load return). LU results are
//   queued in a small FIFO and drained into idle writeback slots. If the FIFO
//   has been denied the port for MAX_WAIT consecutive cycles, the pipeline is
//   stalled for one cycle so the FIFO head can be written.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pipe_valid_in            WB-stage instruction valid
//   pipe_rd_valid_in         WB-stage instruction writes rd
//   pipe_rd_addr_in/value_in WB-stage destination and data
//   pipe_stall_out           hold MEM_WB; the pipe write was not performed
//   lu_valid_in              LU result valid
//   lu_ready_out             FIFO can accept an LU result
//   lu_rd_addr_in/value_in   LU destination and data
//   rf_wr_en_out             register-file write enable
//   rf_rd_addr_out/value_out register-file write address / data
//   fifo_count_out           FIFO occupancy
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_valid_in,
    input  logic                     pipe_rd_valid_in,
    input  logic [4:0]               pipe_rd_addr_in,
    input  logic [31:0]              pipe_rd_value_in,
    output logic                     pipe_stall_out,
    input  logic                     lu_valid_in,
    output logic                     lu_ready_out,
    input  logic [4:0]               lu_rd_addr_in,
    input  logic [31:0]              lu_rd_value_in,
    output logic                     rf_wr_en_out,
    output logic [4:0]               rf_rd_addr_out,
    output logic [31:0]              rf_rd_value_out,
    output logic [$clog2(DEPTH):0]   fifo_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [WW-1:0] MAX_W   = WW'(MAX_WAIT);

    logic [4:0]    addr_mem_q [DEPTH];
    logic [31:0]   value_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    logic pipe_need;
    logic fifo_nonempty;
    logic force_drain;
    logic grant_fifo;
    logic grant_pipe;
    logic push;
    logic pop;

    always_comb begin
        pipe_need     = pipe_valid_in & pipe_rd_valid_in & (pipe_rd_addr_in != 5'd0);
        fifo_nonempty = (count_q != '0);
        force_drain   = fifo_nonempty & (wait_cnt_q == MAX_W);
        // Everything is gated by rst so outputs read zero while reset is held.
        grant_fifo    = !rst & fifo_nonempty & (!pipe_need | force_drain);
        grant_pipe    = !rst & !grant_fifo & pipe_need;
        // Ready comes from the registered count only: a same-cycle pop does
        // not open a slot, which keeps the ready path free of the grant logic.
        lu_ready_out  = !rst & (count_q < DEPTH_C);
        // Results targeting x0 are handshaken but dropped.
        push          = lu_valid_in & lu_ready_out & (lu_rd_addr_in != 5'd0);
        pop           = grant_fifo;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);

        wait_cnt_d = wait_cnt_q;
        if (!fifo_nonempty || pop)  wait_cnt_d = '0;
        else if (wait_cnt_q != MAX_W) wait_cnt_d = wait_cnt_q + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q]  <= lu_rd_addr_in;
            value_mem_q[wr_ptr_q] <= lu_rd_value_in;
        end
    end

    always_comb begin
        rf_wr_en_out    = 1'b0;
        rf_rd_addr_out  = 5'd0;
        rf_rd_value_out = 32'd0;
        pipe_stall_out  = 1'b0;
        if (grant_fifo) begin
            rf_wr_en_out    = 1'b1;
            rf_rd_addr_out  = addr_mem_q[rd_ptr_q];
            rf_rd_value_out = value_mem_q[rd_ptr_q];
            pipe_stall_out  = pipe_need;
        end else if (grant_pipe) begin
            rf_wr_en_out    = 1'b1;
            rf_rd_addr_out  = pipe_rd_addr_in;
            rf_rd_value_out = pipe_rd_value_in;
        end
        fifo_count_out = rst ? '0 : count_q;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid_in, pipe_rd_valid_in;
    logic [4:0]  pipe_rd_addr_in;
    logic [31:0] pipe_rd_value_in;
    logic        pipe_stall_out;
    logic        lu_valid_in, lu_ready_out;
    logic [4:0]  lu_rd_addr_in;
    logic [31:0] lu_rd_value_in;
    logic        rf_wr_en_out;
    logic [4:0]  rf_rd_addr_out;
    logic [31:0] rf_rd_value_out;
    logic [2:0]  fifo_count_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_valid_in    (pipe_valid_in),
        .pipe_rd_valid_in (pipe_rd_valid_in),
        .pipe_rd_addr_in  (pipe_rd_addr_in),
        .pipe_rd_value_in (pipe_rd_value_in),
        .pipe_stall_out   (pipe_stall_out),
        .lu_valid_in      (lu_valid_in),
        .lu_ready_out     (lu_ready_out),
        .lu_rd_addr_in    (lu_rd_addr_in),
        .lu_rd_value_in   (lu_rd_value_in),
        .rf_wr_en_out     (rf_wr_en_out),
        .rf_rd_addr_out   (rf_rd_addr_out),
        .rf_rd_value_out  (rf_rd_value_out),
        .fifo_count_out   (fifo_count_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, then sample 1 ns later so the
    // combinational outputs are settled well before the next rising edge.
    task automatic step(input logic r, input logic pv, input logic [4:0] pa,
                        input logic [31:0] pd, input logic lv,
                        input logic [4:0] la, input logic [31:0] ld);
        @(negedge clk);
        rst              = r;
        pipe_valid_in    = pv;
        pipe_rd_valid_in = pv;
        pipe_rd_addr_in  = pa;
        pipe_rd_value_in = pd;
        lu_valid_in      = lv;
        lu_rd_addr_in    = la;
        lu_rd_value_in   = ld;
        #1;
    endtask

    task automatic chk_port(input string tag, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input logic stall);
        chk({tag, ".wr_en"}, 32'(rf_wr_en_out), 32'(en));
        chk({tag, ".addr"},  32'(rf_rd_addr_out), 32'(a));
        chk({tag, ".data"},  rf_rd_value_out, d);
        chk({tag, ".stall"}, 32'(pipe_stall_out), 32'(stall));
    endtask

    initial begin
        rst = 1'b1;
        pipe_valid_in = 0; pipe_rd_valid_in = 0; pipe_rd_addr_in = 0; pipe_rd_value_in = 0;
        lu_valid_in = 0; lu_rd_addr_in = 0; lu_rd_value_in = 0;

        // 1: reset held two cycles with LU valid asserted
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
            chk_port("rst_hold", 0, 0, 0, 0);
            chk("rst_hold.ready", 32'(lu_ready_out), 0);
            chk("rst_hold.count", 32'(fifo_count_out), 0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst.count", 32'(fifo_count_out), 0);
        chk("post_rst.ready", 32'(lu_ready_out), 1);
        chk_port("post_rst", 0, 0, 0, 0);

        // 2: pipe writes, same cycle
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk_port("pipe_x5", 1, 5'd5, 32'hDEADBEEF, 0);
        step(0, 1, 5'd0, 32'h12345678, 0, 0, 0);
        chk_port("pipe_x0", 0, 0, 0, 0);
        step(0, 0, 5'd5, 32'h12345678, 0, 0, 0);
        pipe_rd_valid_in = 1'b1;
        #1;
        chk_port("pipe_invalid", 0, 0, 0, 0);

        // 3: single LU result with pipe idle; no bypass
        step(0, 0, 0, 0, 1, 5'd7, 32'h00001234);
        chk("lu_x7.ready", 32'(lu_ready_out), 1);
        chk_port("lu_x7.accept", 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lu_x7.count1", 32'(fifo_count_out), 1);
        chk_port("lu_x7.write", 1, 5'd7, 32'h00001234, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lu_x7.count0", 32'(fifo_count_out), 0);
        chk_port("lu_x7.idle", 0, 0, 0, 0);

        // 4: starvation forcing; push cycle plus 8 pipe grants, then stall
        step(0, 1, 5'd10, 32'd100, 1, 5'd9, 32'hA5A5A5A5);
        chk_port("starve.push", 1, 5'd10, 32'd100, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 5'(10 + i), 32'(100 + i), 0, 0, 0);
            chk_port("starve.pipe", 1, 5'(10 + i), 32'(100 + i), 0);
            chk("starve.count", 32'(fifo_count_out), 1);
        end
        step(0, 1, 5'd20, 32'h0BADF00D, 0, 0, 0);
        chk_port("starve.force", 1, 5'd9, 32'hA5A5A5A5, 1);
        step(0, 1, 5'd20, 32'h0BADF00D, 0, 0, 0);
        chk_port("starve.replay", 1, 5'd20, 32'h0BADF00D, 0);
        chk("starve.count0", 32'(fifo_count_out), 0);

        // 5: fill FIFO while pipe is busy, back-pressure, in-order drain
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 5'd11, 32'h55, 1, 5'(21 + k), 32'(32'h100 + k));
            chk("fill.ready", 32'(lu_ready_out), 1);
            chk("fill.count", 32'(fifo_count_out), 32'(k));
            chk_port("fill.pipe", 1, 5'd11, 32'h55, 0);
        end
        step(0, 1, 5'd11, 32'h55, 1, 5'd25, 32'h104);
        chk("full.ready", 32'(lu_ready_out), 0);
        chk("full.count", 32'(fifo_count_out), 4);
        chk_port("full.pipe", 1, 5'd11, 32'h55, 0);
        // pipe goes idle; x25 still held by the LU
        step(0, 0, 0, 0, 1, 5'd25, 32'h104);
        chk("drain0.ready", 32'(lu_ready_out), 0);
        chk("drain0.count", 32'(fifo_count_out), 4);
        chk_port("drain0", 1, 5'd21, 32'h100, 0);
        step(0, 0, 0, 0, 1, 5'd25, 32'h104);
        chk("drain1.ready", 32'(lu_ready_out), 1);
        chk("drain1.count", 32'(fifo_count_out), 3);
        chk_port("drain1", 1, 5'd22, 32'h101, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("pushpop.count", 32'(fifo_count_out), 3);
        chk_port("drain2", 1, 5'd23, 32'h102, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_port("drain3", 1, 5'd24, 32'h103, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain4.count", 32'(fifo_count_out), 1);
        chk_port("drain4", 1, 5'd25, 32'h104, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drained.count", 32'(fifo_count_out), 0);
        chk_port("drained", 0, 0, 0, 0);

        // 6: reset with 3 entries queued discards them
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 5'd12, 32'h66, 1, 5'(26 + k), 32'(32'h200 + k));
            chk_port("q3.pipe", 1, 5'd12, 32'h66, 0);
        end
        step(1, 1, 5'd12, 32'h66, 0, 0, 0);
        chk_port("midrst", 0, 0, 0, 0);
        chk("midrst.count", 32'(fifo_count_out), 0);
        chk("midrst.ready", 32'(lu_ready_out), 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("after_rst.count", 32'(fifo_count_out), 0);
            chk("after_rst.ready", 32'(lu_ready_out), 1);
            chk_port("after_rst", 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
